// File: rtl/sha_256_padder_pkg.sv
// sha_256_padder_pkg: padder FSM states, padding constants and SHA-224/256 mode encodings.
package sha_256_padder_pkg;
    typedef enum logic [1:0] {MODE_SHA224 = 2'd0, MODE_SHA256 = 2'd1} sha_mode_t;
    typedef enum logic [2:0] {ST_IDLE, ST_FILL, ST_SEND, ST_WAIT, ST_PAD2} pad_st_t;
    localparam logic [7:0]  PAD_BYTE = 8'h80;
    localparam logic [31:0] PAD_WORD = {PAD_BYTE, 24'h0};
endpackage

// File: rtl/sha_pad_word.sv
// sha_pad_word: keeps the first bytes_i bytes of a big-endian word and places the 0x80 pad byte right after them.
module sha_pad_word
    import sha_256_padder_pkg::*;
(
    input  logic [31:0] data_i,
    input  logic [2:0]  bytes_i,
    output logic [31:0] word_o
);
    logic [5:0] sh;
    assign sh = {bytes_i, 3'b000};
    assign word_o = bytes_i[2] ? data_i : (data_i & ~(32'hffff_ffff >> sh)) | (PAD_WORD >> sh);
endmodule

// File: rtl/sha_256_padder.sv
// sha_256_padder: packs a 32-bit word stream into FIPS 180-4 padded 512-bit blocks and sequences them into the core.
module sha_256_padder
    import sha_256_padder_pkg::*;
#(
    parameter int         LEN_W  = 64,
    parameter logic [1:0] DEF_OP = MODE_SHA256
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [31:0]  in_data,
    input  logic         in_last,
    input  logic [2:0]   in_bytes,
    input  logic [1:0]   in_op,
    output logic [511:0] core_data,
    output logic [63:0]  core_index,
    output logic [1:0]   core_op,
    output logic         core_enable,
    input  logic         core_ready,
    output logic         msg_done
);
    typedef struct packed {
        pad_st_t          st;
        logic [3:0]       wptr;
        logic [LEN_W-1:0] cnt;
        logic [63:0]      idx;
        logic [1:0]       op;
        logic             fin;
        logic             pad2;
        logic             pend;
        logic             rdy;
        logic             en;
    } reg_t;

    reg_t             s_q, s_d;
    logic [31:0]      b_q [16];
    logic [31:0]      b_d [16];
    logic             hs, full, fin;
    logic [3:0]       wp;
    logic [4:0]       used;
    logic [LEN_W-1:0] cnt_n;
    logic [63:0]      len_n, len_q;
    logic [31:0]      pw;

    sha_pad_word u_pad (
        .data_i  (in_data),
        .bytes_i (in_last ? in_bytes : 3'd4),
        .word_o  (pw)
    );

    assign len_n = 64'(cnt_n) << 3;
    assign len_q = 64'(s_q.cnt) << 3;

    always_comb begin
        s_d = s_q;
        b_d = b_q;
        hs = in_valid && s_q.rdy;
        wp = (s_q.st == ST_IDLE) ? 4'd0 : s_q.wptr;
        cnt_n = ((s_q.st == ST_IDLE) ? '0 : s_q.cnt) + (in_last ? LEN_W'(in_bytes) : LEN_W'(4));
        full = in_bytes >= 3'd4;
        // a full last word in slot 15 leaves no room for 0x80, so used saturates at 16
        used = (full && wp != 4'd15) ? 5'(wp) + 5'd2 : 5'(wp) + 5'd1;
        fin = used <= 5'd14;
        case (s_q.st)
            ST_IDLE, ST_FILL: if (hs) begin
                if (s_q.st == ST_IDLE) begin
                    s_d.op = in_op;
                    s_d.idx = 64'd1;
                end
                s_d.cnt = cnt_n;
                s_d.wptr = wp + 4'd1;
                b_d[wp] = pw;
                s_d.st = (in_last || wp == 4'd15) ? ST_SEND : ST_FILL;
                s_d.fin = in_last && fin;
                s_d.pad2 = in_last && !fin;
                s_d.pend = in_last && full && wp == 4'd15;
                if (in_last)
                    for (int i = 0; i < 16; i++)
                        if (4'(i) > wp)
                            b_d[i] = (full && 5'(i) == 5'(wp) + 5'd1) ? PAD_WORD :
                                     (fin && i == 14) ? len_n[63:32] :
                                     (fin && i == 15) ? len_n[31:0] : 32'h0;
            end
            ST_SEND: s_d.st = ST_WAIT;
            ST_WAIT: if (core_ready) begin
                s_d.st = s_q.fin ? ST_IDLE : s_q.pad2 ? ST_PAD2 : ST_FILL;
                s_d.idx = s_q.fin ? s_q.idx : s_q.idx + 64'd1;
                s_d.wptr = 4'd0;
            end
            ST_PAD2: begin
                for (int i = 0; i < 16; i++)
                    b_d[i] = (i == 0 && s_q.pend) ? PAD_WORD :
                             (i == 14) ? len_q[63:32] :
                             (i == 15) ? len_q[31:0] : 32'h0;
                s_d.fin = 1'b1;
                s_d.pad2 = 1'b0;
                s_d.pend = 1'b0;
                s_d.st = ST_SEND;
            end
            default: s_d.st = ST_IDLE;
        endcase
        s_d.rdy = s_d.st == ST_IDLE || s_d.st == ST_FILL;
        s_d.en = s_d.st == ST_SEND;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            s_q <= '{st: ST_IDLE, op: DEF_OP, default: '0};
            b_q <= '{default: '0};
        end else begin
            s_q <= s_d;
            b_q <= b_d;
        end
    end

    for (genvar g = 0; g < 16; g++) begin : g_data
        assign core_data[g*32 +: 32] = b_q[g];
    end

    assign in_ready    = s_q.rdy;
    assign core_enable = s_q.en;
    assign core_index  = s_q.idx;
    assign core_op     = s_q.op;
    assign msg_done    = rst && s_q.st == ST_WAIT && s_q.fin && core_ready;
endmodule
